recirc_buf_ctrl: RTL and testbench
==================================

Name: recirc_buf_ctrl

Overview:
- Per-port controller for one recirculation buffer in speculative network scheme 2.
- Packets that lose output arbitration at the transceiver are diverted into the recirculation loop. This block queues their destinations, raises one buffer request at a time to the recirculation allocator, and sequences the buffer-to-switch transmit slot on grant.
- Stale entries are dropped after a bounded wait.
- One instance per input port; the allocator arbitrates between it and the transceiver.

Parameters:
- PORTS, 4, number of switch ports; port field width PW = log2(PORTS).
- FIFO_DEPTH, 4, recirculation entries held; power of two, at least 2.
- SLOT_SIZE, 4, cycles one packet occupies the switch path; at least 2.
- TIMEOUT, 16, REQ cycles without grant before the head entry is discarded; at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- nog_valid  in  1  packet diverted into recirculation this cycle.
- nog_port  in  PW  destination port of the diverted packet.
- grant_buf_valid  in  1  allocator buffer grant (grant_buf[k].valid).
- req_buf_valid  out  1  buffer request to allocator (req_buf[k].valid).
- req_buf_port  out  PW  requested output port (req_buf[k].port).
- tx_en  out  1  buffer drives the switch this cycle.
- tx_port  out  PW  output port being transmitted to.
- occupancy  out  log2(FIFO_DEPTH)+1  entries held.
- full  out  1  occupancy equals FIFO_DEPTH.
- drop  out  1  one-cycle pulse: push rejected because the buffer was full.
- timeout  out  1  one-cycle pulse: head entry discarded after TIMEOUT.

Behaviour:
Reset
- rst low asynchronously clears all outputs to 0: req_buf_valid, req_buf_port, tx_en, tx_port, occupancy, full, drop, timeout.
- Reset also clears read pointer, write pointer, wait counter and slot counter, and puts the FSM in IDLE.
- Reset mid-TX or mid-REQ abandons the entry; no pulse is emitted.

Storage and pointers
- Circular FIFO of PW-bit entries with log2(FIFO_DEPTH)-bit pointers; pointers wrap modulo FIFO_DEPTH.
- Push when nog_valid=1 and full=0 (full as registered at the start of the cycle).
- Push when full=1 is rejected even if a pop occurs in the same cycle; drop=1 the next cycle.
- Pop on the last TX cycle or on a timeout.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- occupancy and full update the cycle after the push or pop edge.

FSM (all outputs registered)
- IDLE:
  - req_buf_valid=0, tx_en=0.
  - Go to REQ when occupancy>0.
  - A push into an empty buffer at edge t gives req_buf_valid=1 from t+2.
- REQ:
  - req_buf_valid=1, req_buf_port = head entry (held stable).
  - Wait counter increments each REQ cycle.
  - grant_buf_valid=1: go to TX next cycle and clear the wait counter.
  - No grant with wait counter at TIMEOUT-1: pop the head, pulse timeout, clear the wait counter, go to REQ if entries remain after the pop, otherwise IDLE.
  - Grant and expiry in the same cycle: grant wins.
- TX:
  - req_buf_valid=0, tx_en=1, tx_port = head, for exactly SLOT_SIZE cycles (slot counter 0..SLOT_SIZE-1).
  - On the cycle with slot counter at SLOT_SIZE-1: pop, then go to REQ if remaining occupancy>0, otherwise IDLE.
  - Consecutive entries therefore have one REQ cycle minimum between slots.
- grant_buf_valid outside REQ is ignored.
- Pushes continue during REQ and TX.

Invariants
- req_buf_valid and tx_en are never both 1.
- req_buf_valid is never 1 while occupancy=0.

Test Plan:
1. Push dest 2 into empty buffer at cycle 0; grant_buf_valid=1 at cycle 3 -> req_buf_valid=1, req_buf_port=2 from cycle 2; tx_en=1, tx_port=2 cycles 4-7; occupancy 1 -> 0 after cycle 7; IDLE.
2. Push 1,3,0,2 back-to-back, then push 1 while full -> full=1, drop pulses once; transmit order 1,3,0,2; occupancy reaches 0.
3. Push dest 3, never grant -> req_buf_valid high for 16 cycles, then timeout pulses for one cycle, occupancy=0, IDLE.
4. Grant arrives on 16th REQ cycle (the expiry cycle) -> TX entered, no timeout pulse.
5. Full buffer with push on the pop cycle of entry 0 -> push dropped, occupancy 4 -> 3; pointer wrap verified over 10 pushes and pops.
6. Assert rst low mid-TX (slot counter 2) -> all outputs 0 immediately; after release, IDLE with occupancy=0; grant_buf_valid pulse while IDLE is ignored.

Source files
------------

// File: rtl/recirc_buf_ctrl.sv
// rtl/recirc_buf_ctrl.sv - recirculation buffer queue, request and transmit-slot sequencer
// Queues diverted destinations, requests one buffer slot at a time and drops stale heads.
module recirc_buf_ctrl #(
  parameter int PORTS      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SLOT_SIZE  = 4,
  parameter int TIMEOUT    = 16,
  localparam int PW = $clog2(PORTS),
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int OW = AW + 1,
  localparam int WW = $clog2(TIMEOUT),
  localparam int SW = $clog2(SLOT_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nog_valid,
  input  logic [PW-1:0] nog_port,
  input  logic          grant_buf_valid,
  output logic          req_buf_valid,
  output logic [PW-1:0] req_buf_port,
  output logic          tx_en,
  output logic [PW-1:0] tx_port,
  output logic [OW-1:0] occupancy,
  output logic          full,
  output logic          drop,
  output logic          timeout
);

  typedef enum logic [1:0] {IDLE, REQ, TX} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          full_q, full_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          req_valid_q, req_valid_d;
  logic [PW-1:0] req_port_q, req_port_d;
  logic          tx_en_q, tx_en_d;
  logic [PW-1:0] tx_port_q, tx_port_d;
  logic          drop_q, drop_d;
  logic          timeout_q, timeout_d;
  logic          push, pop;
  logic [PW-1:0] head;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    wait_d    = wait_q;
    slot_d    = slot_q;
    pop       = 1'b0;
    timeout_d = 1'b0;
    // Full is judged on the registered flag, so a same-cycle pop never frees room.
    push      = nog_valid && !full_q;
    drop_d    = nog_valid && full_q;

    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (occ_q != '0) state_d = REQ;
      end
      REQ: begin
        if (grant_buf_valid) begin
          state_d = TX;
          wait_d  = '0;
          slot_d  = '0;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          pop       = 1'b1;
          timeout_d = 1'b1;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      TX: begin
        if (slot_q == SW'(SLOT_SIZE - 1)) begin
          pop    = 1'b1;
          slot_d = '0;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    occ_d  = occ_q + OW'(push) - OW'(pop);
    full_d = (occ_d == OW'(FIFO_DEPTH));

    if (pop) state_d = (occ_d != '0) ? REQ : IDLE;

    // A push landing in the slot that becomes head this cycle is not yet in memory.
    head = (push && (wr_ptr_q == rd_ptr_d)) ? nog_port : mem_q[rd_ptr_d];

    req_valid_d = (state_d == REQ);
    req_port_d  = (state_d == REQ) ? head : req_port_q;
    tx_en_d     = (state_d == TX);
    tx_port_d   = (state_q == REQ && state_d == TX) ? req_port_q : tx_port_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= nog_port;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      wait_q      <= '0;
      slot_q      <= '0;
      req_valid_q <= 1'b0;
      req_port_q  <= '0;
      tx_en_q     <= 1'b0;
      tx_port_q   <= '0;
      drop_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      wait_q      <= wait_d;
      slot_q      <= slot_d;
      req_valid_q <= req_valid_d;
      req_port_q  <= req_port_d;
      tx_en_q     <= tx_en_d;
      tx_port_q   <= tx_port_d;
      drop_q      <= drop_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_buf_valid = req_valid_q;
  assign req_buf_port  = req_port_q;
  assign tx_en         = tx_en_q;
  assign tx_port       = tx_port_q;
  assign occupancy     = occ_q;
  assign full          = full_q;
  assign drop          = drop_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_recirc_buf_ctrl.sv
// tb/tb_recirc_buf_ctrl.sv - scoreboard bench for recirc_buf_ctrl
// Expected destinations are queued at push time and matched at transmit start or timeout.
module tb_recirc_buf_ctrl;

  localparam int PW = 2;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          nog_valid = 1'b0;
  logic [PW-1:0] nog_port = '0;
  logic          grant_buf_valid = 1'b0;
  logic          req_buf_valid;
  logic [PW-1:0] req_buf_port;
  logic          tx_en;
  logic [PW-1:0] tx_port;
  logic [OW-1:0] occupancy;
  logic          full;
  logic          drop;
  logic          timeout;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned sb_q[$];
  logic tx_en_prev = 1'b0;

  recirc_buf_ctrl #(.PORTS(4), .FIFO_DEPTH(4), .SLOT_SIZE(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst_n), .nog_valid(nog_valid), .nog_port(nog_port),
    .grant_buf_valid(grant_buf_valid), .req_buf_valid(req_buf_valid),
    .req_buf_port(req_buf_port), .tx_en(tx_en), .tx_port(tx_port),
    .occupancy(occupancy), .full(full), .drop(drop), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {24'd0, req_buf_valid, req_buf_port, tx_en, tx_port, full},  32'd0);
    check_eq({tag, "_occ"}, 32'(occupancy), 32'd0);
    check_eq({tag, "_pulses"}, {30'd0, drop, timeout}, 32'd0);
  endtask

  // Drives one push for a cycle; exp_accept is what the bench expects of the buffer.
  task automatic push(input int unsigned port, input bit exp_accept);
    nog_valid = 1'b1;
    nog_port  = PW'(port);
    if (exp_accept) sb_q.push_back(port);
    tick();
    nog_valid = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && !req_buf_valid; i++) tick();
    check_eq("wait_req", 32'(req_buf_valid), 32'd1);
  endtask

  task automatic serve_one();
    wait_req();
    check_eq("sb_head", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) check_eq("req_port", 32'(req_buf_port), sb_q[0]);
    grant_buf_valid = 1'b1;
    tick();
    grant_buf_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("tx_en_slot", 32'(tx_en), 32'd1);
      tick();
    end
    check_eq("tx_en_end", 32'(tx_en), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("inv_excl", 32'(req_buf_valid && tx_en), 32'd0);
      check_eq("inv_req_occ", 32'(req_buf_valid && occupancy == '0), 32'd0);
      if (tx_en && !tx_en_prev) begin
        check_eq("tx_sb_has", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) check_eq("tx_port", 32'(tx_port), sb_q.pop_front());
      end
      if (timeout) begin
        check_eq("to_sb_has", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      tx_en_prev <= tx_en;
    end else begin
      tx_en_prev <= 1'b0;
    end
  end

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single entry, grant on cycle 3
    push(2, 1'b1);
    check_eq("t1_occ1", 32'(occupancy), 32'd1);
    check_eq("t1_req_c1", 32'(req_buf_valid), 32'd0);
    tick();
    check_eq("t1_req_c2", 32'(req_buf_valid), 32'd1);
    check_eq("t1_port_c2", 32'(req_buf_port), 32'd2);
    tick();
    check_eq("t1_req_c3", 32'(req_buf_valid), 32'd1);
    grant_buf_valid = 1'b1;
    tick();
    grant_buf_valid = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      check_eq("t1_tx_en", 32'(tx_en), 32'd1);
      check_eq("t1_tx_port", 32'(tx_port), 32'd2);
      check_eq("t1_occ_tx", 32'(occupancy), 32'd1);
      tick();
    end
    check_eq("t1_tx_off", 32'(tx_en), 32'd0);
    check_eq("t1_occ0", 32'(occupancy), 32'd0);
    tick();
    check_eq("t1_idle", 32'(req_buf_valid), 32'd0);

    // 2: fill, overflow once, drain in order
    push(1, 1'b1);
    push(3, 1'b1);
    push(0, 1'b1);
    push(2, 1'b1);
    check_eq("t2_full", 32'(full), 32'd1);
    check_eq("t2_occ4", 32'(occupancy), 32'd4);
    push(1, 1'b0);
    check_eq("t2_drop", 32'(drop), 32'd1);
    tick();
    check_eq("t2_drop_once", 32'(drop), 32'd0);
    for (int k = 0; k < 4; k++) serve_one();
    check_eq("t2_occ0", 32'(occupancy), 32'd0);
    check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // 3: never granted
    push(3, 1'b1);
    wait_req();
    cnt = 0;
    for (int i = 0; i < 40 && req_buf_valid; i++) begin
      check_eq("t3_no_to", 32'(timeout), 32'd0);
      cnt++;
      tick();
    end
    check_eq("t3_req_cycles", 32'(cnt), 32'd16);
    check_eq("t3_timeout", 32'(timeout), 32'd1);
    check_eq("t3_occ0", 32'(occupancy), 32'd0);
    tick();
    check_eq("t3_to_pulse", 32'(timeout), 32'd0);
    check_eq("t3_idle", 32'(req_buf_valid), 32'd0);
    check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4: grant on the expiry cycle wins
    push(0, 1'b1);
    wait_req();
    for (int i = 0; i < 15; i++) tick();
    check_eq("t4_req16", 32'(req_buf_valid), 32'd1);
    grant_buf_valid = 1'b1;
    tick();
    grant_buf_valid = 1'b0;
    check_eq("t4_tx", 32'(tx_en), 32'd1);
    check_eq("t4_no_to", 32'(timeout), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t4_done", 32'(tx_en), 32'd0);
    check_eq("t4_occ0", 32'(occupancy), 32'd0);
    check_eq("t4_no_to_end", 32'(timeout), 32'd0);

    // 5: push on the pop cycle of a full buffer, then pointer wrap
    push(3, 1'b1);
    push(2, 1'b1);
    push(1, 1'b1);
    push(0, 1'b1);
    wait_req();
    grant_buf_valid = 1'b1;
    tick();
    grant_buf_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t5_last_slot", 32'(tx_en), 32'd1);
    check_eq("t5_full", 32'(full), 32'd1);
    push(1, 1'b0);
    check_eq("t5_drop", 32'(drop), 32'd1);
    check_eq("t5_occ3", 32'(occupancy), 32'd3);
    check_eq("t5_req_next", 32'(req_buf_valid), 32'd1);
    for (int k = 0; k < 3; k++) serve_one();
    for (int k = 0; k < 10; k++) begin
      push($urandom_range(0, 3), 1'b1);
      serve_one();
    end
    check_eq("t5_occ0", 32'(occupancy), 32'd0);
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: reset in the middle of a transmit slot
    push(2, 1'b1);
    wait_req();
    grant_buf_valid = 1'b1;
    tick();
    grant_buf_valid = 1'b0;
    tick();
    tick();
    check_eq("t6_mid_tx", 32'(tx_en), 32'd1);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1 check_all_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    grant_buf_valid = 1'b1;
    tick();
    grant_buf_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_all_zero("t6_idle");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
